bit_swap_engine: RTL and testbench
==================================

// Module: bit_swap_engine
// PURPOSE
// - Hardware swap unit: the execution end for swap stimulus generated by the team's benches.
// - Accepts operand pairs (a, b) plus a swap command on a valid/ready input stream.
// - Commands: pass-through, word exchange a<->b, bit exchange inside a, bit exchange between a and b.
// - Returns results on a valid/ready output stream through a 2-stage pipeline with full backpressure.
// PARAMETERS
// - WIDTH   8                    operand width in bits (>=2)
// - POS_W   $clog2(WIDTH)+1      bit-position field width; wide enough to encode out-of-range values
// - CNT_W   16                   width of the completed-transaction counter
// PORTS
// - clk        in   1      single clock; all logic on posedge
// - rst        in   1      synchronous, active-high reset
// - in_valid   in   1      input command valid
// - in_ready   out  1      engine can accept a command this cycle
// - in_a       in   WIDTH  operand a
// - in_b       in   WIDTH  operand b
// - in_mode    in   2      00 pass, 01 word swap, 10 bit swap in a, 11 bit swap a[i] with b[j]
// - in_pos_i   in   POS_W  first bit position (i)
// - in_pos_j   in   POS_W  second bit position (j)
// - out_valid  out  1      result valid
// - out_ready  in   1      downstream accepts result
// - out_a      out  WIDTH  result a
// - out_b      out  WIDTH  result b
// - out_err    out  1      position out of range; result equals the inputs unchanged
// - txn_count  out  CNT_W  number of completed output handshakes
// BEHAVIOUR
// - Reset, sampled on posedge clk while rst=1:
//   - s1_valid=0, s2_valid=0.
//   - out_valid=0, out_a=0, out_b=0, out_err=0, txn_count=0.
//   - in_ready=0 while rst=1; in_ready=1 on the first cycle after rst deasserts.
//   - Reset mid-operation discards all in-flight commands; no result for them ever appears.
// - Handshakes:
//   - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
//   - in_valid must hold with stable data until accepted. out_* hold stable while out_valid & !out_ready.
// - Pipeline:
//   - S1 registers operands, mode and range-check flag.
//   - S2 registers the computed result, which drives out_*.
//   - adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 & !rst.
//   - Latency: a command accepted at edge N gives out_valid=1 after edge N+1, when there is no stall.
//   - Throughput: 1 command/cycle with out_ready=1.
//   - Simultaneous output handshake and input accept in the same cycle is legal; no bubble is inserted.
// - Range check:
//   - err = (mode==10 | mode==11) & (pos_i>=WIDTH | pos_j>=WIDTH). Modes 00 and 01 ignore positions; err=0.
//   - When err=1: out_a=a, out_b=b, out_err=1.
// - Compute (no error):
//   - 00: out_a=a, out_b=b.
//   - 01: out_a=b, out_b=a.
//   - 10: out_a=a with bits i and j exchanged; out_b=b. i==j leaves a unchanged.
//   - 11: out_a=a with a[i]<-b[j]; out_b=b with b[j]<-a[i]. Both read pre-swap values.
// - txn_count increments by 1 on each output handshake. It wraps from 2^CNT_W-1 to 0.
// TESTING
// - T1 reset: rst=1 for 2 cycles, then low -> out_valid=0, txn_count=0, in_ready=1 on the first cycle after rst deasserts.
// - T2 word swap: mode=01, a=16, b=20, out_ready=1 -> 2 cycles later out_a=20, out_b=16, out_err=0, txn_count=1.
// - T3 bit swap in a: mode=10, a=8'b0010_0000, i=5, j=2 -> out_a=8'b0000_0100. Then i=j=3, a=8'h08 -> out_a=8'h08.
// - T4 cross swap: mode=11, a=8'h10, b=8'h14, i=4, j=1 -> out_a=8'h00, out_b=8'h16.
// - T5 error/backpressure: mode=10, i=9, a=8'hA5 -> out_err=1, out_a=8'hA5.
//   Then 4 back-to-back commands with out_ready=0 -> in_ready drops after 2 accepts, out_* stay stable.
//   Raise out_ready -> all 4 results emerge in order.
// - T6 reset mid-flight: 2 commands in pipe, rst=1 for 1 cycle -> neither result appears, txn_count=0.
//   Also preload txn_count=65535 via 65535 transfers -> the next transfer wraps txn_count to 0.

Source files
------------

// File: rtl/bit_swap_engine.sv
// Two-stage swap unit: operands, mode and range flag are registered in S1.
// S2 holds the swapped result that drives the output stream.
module bit_swap_engine #(
  parameter int WIDTH = 8,
  parameter int POS_W = $clog2(WIDTH) + 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic [POS_W-1:0] in_pos_i,
  input  logic [POS_W-1:0] in_pos_j,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_err,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [POS_W-1:0] LIMIT = POS_W'(WIDTH);

  // Handshake: a transfer happens on a posedge where valid & ready are both 1;
  // a producer holds valid and data stable until that edge.
  logic             adv1, adv2, in_fire, out_fire, in_err;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic [POS_W-1:0] s1_pos_i_q, s1_pos_i_d, s1_pos_j_q, s1_pos_j_d;
  logic             s1_err_q, s1_err_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic             s2_err_q, s2_err_d;
  logic [CNT_W-1:0] txn_count_q, txn_count_d;
  logic             a_i, a_j, b_j;
  logic [WIDTH-1:0] res_a, res_b;

  always_comb begin
    adv2     = !s2_valid_q | out_ready;
    adv1     = !s1_valid_q | adv2;
    in_ready = adv1 & !rst;
    in_fire  = in_valid & in_ready;
    out_fire = s2_valid_q & out_ready;
    in_err   = in_mode[1] & ((in_pos_i >= LIMIT) | (in_pos_j >= LIMIT));
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    s1_pos_i_d = s1_pos_i_q;
    s1_pos_j_d = s1_pos_j_q;
    s1_err_d   = s1_err_q;
    if (adv1) s1_valid_d = in_valid;
    if (in_fire) begin
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_mode_d  = in_mode;
      s1_pos_i_d = in_pos_i;
      s1_pos_j_d = in_pos_j;
      s1_err_d   = in_err;
    end
  end

  // Positions are matched against every bit index so no out-of-range select exists.
  always_comb begin
    a_i   = 1'b0;
    a_j   = 1'b0;
    b_j   = 1'b0;
    res_a = s1_a_q;
    res_b = s1_b_q;
    for (int k = 0; k < WIDTH; k++) begin
      if (POS_W'(k) == s1_pos_i_q) a_i = s1_a_q[k];
      if (POS_W'(k) == s1_pos_j_q) a_j = s1_a_q[k];
      if (POS_W'(k) == s1_pos_j_q) b_j = s1_b_q[k];
    end
    if (!s1_err_q) begin
      case (s1_mode_q)
        2'b01: begin
          res_a = s1_b_q;
          res_b = s1_a_q;
        end
        2'b10: begin
          for (int k = 0; k < WIDTH; k++) begin
            if (POS_W'(k) == s1_pos_i_q) res_a[k] = a_j;
            if (POS_W'(k) == s1_pos_j_q) res_a[k] = a_i;
          end
        end
        2'b11: begin
          for (int k = 0; k < WIDTH; k++) begin
            if (POS_W'(k) == s1_pos_i_q) res_a[k] = b_j;
            if (POS_W'(k) == s1_pos_j_q) res_b[k] = a_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_a_d      = s2_a_q;
    s2_b_d      = s2_b_q;
    s2_err_d    = s2_err_q;
    txn_count_d = txn_count_q + CNT_W'(out_fire);
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_a_d   = res_a;
        s2_b_d   = res_b;
        s2_err_d = s1_err_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= '0;
      s1_pos_i_q  <= '0;
      s1_pos_j_q  <= '0;
      s1_err_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_a_q      <= '0;
      s2_b_q      <= '0;
      s2_err_q    <= 1'b0;
      txn_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      s1_pos_i_q  <= s1_pos_i_d;
      s1_pos_j_q  <= s1_pos_j_d;
      s1_err_q    <= s1_err_d;
      s2_valid_q  <= s2_valid_d;
      s2_a_q      <= s2_a_d;
      s2_b_q      <= s2_b_d;
      s2_err_q    <= s2_err_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_a     = s2_a_q;
  assign out_b     = s2_b_q;
  assign out_err   = s2_err_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_bit_swap_engine.sv
// Bench for bit_swap_engine: directed scenarios plus random traffic, all results
// checked against an arithmetic swap model and an in-flight expected queue.
module tb_bit_swap_engine;
  localparam int W  = 8;
  localparam int PW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b;
  logic [1:0]    in_mode;
  logic [PW-1:0] in_pos_i, in_pos_j;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_a, out_b;
  logic          out_err;
  logic [CW-1:0] txn_count;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;

  logic [2*W:0]  exp_q[$];
  logic [CW-1:0] model_cnt;
  logic          hold_prev;
  logic [W-1:0]  prev_a, prev_b;
  logic          prev_err;

  bit_swap_engine #(.WIDTH(W), .POS_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .in_pos_i(in_pos_i), .in_pos_j(in_pos_j),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_err(out_err),
    .txn_count(txn_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {err, a, b} from plain shift/mask arithmetic on the command.
  function automatic logic [2*W:0] ref_swap(input logic [1:0] m, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input int i, input int j);
    int ra, rb, bi, bj;
    ra = int'(a);
    rb = int'(b);
    if (m[1] && (i >= W || j >= W)) return {1'b1, a, b};
    case (m)
      2'b01: begin ra = int'(b); rb = int'(a); end
      2'b10: begin
        bi = (int'(a) >> i) & 1;
        bj = (int'(a) >> j) & 1;
        ra = (ra & ~(1 << i) & ~(1 << j)) | (bj << i) | (bi << j);
      end
      2'b11: begin
        bi = (int'(a) >> i) & 1;
        bj = (int'(b) >> j) & 1;
        ra = (ra & ~(1 << i)) | (bj << i);
        rb = (rb & ~(1 << j)) | (bi << j);
      end
      default: ;
    endcase
    return {1'b0, W'(ra), W'(rb)};
  endfunction

  // scoreboard / compare process
  always @(negedge clk) begin
    logic [2*W:0] e;
    if (rst) begin
      exp_q.delete();
      model_cnt = '0;
      hold_prev = 1'b0;
    end else begin
      check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
      check("txn_count", 32'(txn_count), 32'(model_cnt));
      check("spurious_out_valid", 32'(out_valid && exp_q.size() == 0), 32'd0);
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_a", 32'(out_a), 32'(prev_a));
        check("hold_b", 32'(out_b), 32'(prev_b));
        check("hold_err", 32'(out_err), 32'(prev_err));
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("res_err", 32'(out_err), 32'(e[2*W]));
        check("res_a", 32'(out_a), 32'(e[2*W-1:W]));
        check("res_b", 32'(out_b), 32'(e[W-1:0]));
        model_cnt = model_cnt + 1'b1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_swap(in_mode, in_a, in_b, int'(in_pos_i), int'(in_pos_j)));
        acc_cnt++;
      end
      hold_prev = out_valid && !out_ready;
      prev_a    = out_a;
      prev_b    = out_b;
      prev_err  = out_err;
    end
  end

  // driver tasks
  task automatic send(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [PW-1:0] i, input logic [PW-1:0] j);
    bit got = 1'b0;
    in_mode = m; in_a = a; in_b = b; in_pos_i = i; in_pos_j = j;
    in_valid = 1'b1;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    if (!got) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb,
                          input logic ee);
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    check({name, "_a"}, 32'(out_a), 32'(ea));
    check({name, "_b"}, 32'(out_b), 32'(eb));
    check({name, "_err"}, 32'(out_err), 32'(ee));
    @(posedge clk); #1;
  endtask

  task automatic randomize_cmd();
    in_mode  = 2'($urandom_range(0, 3));
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_pos_i = PW'($urandom_range(0, 9));
    in_pos_j = PW'($urandom_range(0, 9));
  endtask

  initial begin
    int acc0;
    logic acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_mode = '0; in_pos_i = '0; in_pos_j = '0;

    // model pins
    check("model_t3a", 32'(ref_swap(2'b10, 8'h20, 8'h00, 5, 2)), 32'h00400);
    check("model_t4", 32'(ref_swap(2'b11, 8'h10, 8'h14, 4, 1)), 32'h00016);
    check("model_err", 32'(ref_swap(2'b11, 8'h5A, 8'h3C, 2, 8)), 32'h15A3C);

    // T1 reset
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    check("t1_out_valid", 32'(out_valid), 32'd0);
    check("t1_txn", 32'(txn_count), 32'd0);
    check("t1_out_a", 32'(out_a), 32'd0);
    @(posedge clk); #1;

    // T2 word swap with latency
    send(2'b01, 8'd16, 8'd20, 4'd0, 4'd0);
    @(negedge clk);
    check("t2_early_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_a", 32'(out_a), 32'd20);
    check("t2_b", 32'(out_b), 32'd16);
    check("t2_err", 32'(out_err), 32'd0);
    @(negedge clk);
    check("t2_txn", 32'(txn_count), 32'd1);
    @(posedge clk); #1;

    // T3 / T4
    send(2'b10, 8'b0010_0000, 8'h00, 4'd5, 4'd2);
    wait_out("t3a", 8'b0000_0100, 8'h00, 1'b0);
    send(2'b10, 8'h08, 8'h00, 4'd3, 4'd3);
    wait_out("t3b", 8'h08, 8'h00, 1'b0);
    send(2'b11, 8'h10, 8'h14, 4'd4, 4'd1);
    wait_out("t4", 8'h00, 8'h16, 1'b0);

    // T5 error then backpressure
    send(2'b10, 8'hA5, 8'h00, 4'd9, 4'd1);
    wait_out("t5_err", 8'hA5, 8'h00, 1'b1);
    out_ready = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          send(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), PW'(k + 1), PW'(6 - k));
        end
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    check("t5_accepts", 32'(acc_cnt - acc0), 32'd2);
    check("t5_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    wait fork;
    repeat (4) @(posedge clk);
    #1;
    check("t5_all_out", 32'(exp_q.size()), 32'd0);

    // random traffic with random backpressure
    in_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        randomize_cmd();
        in_valid = ($urandom_range(0, 9) < 7);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // T6 reset with two commands in flight
    out_ready = 1'b0;
    send(2'b01, 8'h11, 8'h22, 4'd0, 4'd0);
    send(2'b01, 8'h33, 8'h44, 4'd0, 4'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t6_no_out", 32'(out_valid), 32'd0);
    end
    check("t6_txn", 32'(txn_count), 32'd0);
    @(posedge clk); #1;

    // counter wrap
    in_valid = 1'b1;
    repeat (65535) begin
      randomize_cmd();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wrap_full", 32'(txn_count), 32'hFFFF);
    send(2'b00, 8'h5A, 8'hC3, 4'd0, 4'd0);
    wait_out("wrap_last", 8'h5A, 8'hC3, 1'b0);
    @(negedge clk);
    check("wrap_zero", 32'(txn_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
